// File: rtl/meter_scheduler.sv
// Parking-meter time keeper: serialises button presses and 1 Hz ticks onto one remaining-time register and drives a blink enable.
// Latency: an isolated input rising edge updates timeRemain 4 clk edges after it is first sampled high (sync x2, pend, grant).
// Backpressure: none upstream; simultaneous requests queue in per-source pending bits and are granted one per cycle by fixed priority.
//
// Ports:
//   clk, rst_n            - core clock, asynchronous active-low reset
//   clk1HZ, clk20HZ       - slow async square waves (decrement tick, blink time base)
//   Add10..Add550,
//   Reset10, Reset205     - async debounced button levels
//   timeRemain [13:0]     - remaining seconds (registered)
//   disp_on               - display enable for blinking (registered)
//   mstate [1:0]          - NORMAL=0, LOW=1, EXPIRED=2 (decoded from timeRemain)
//   served [6:0]          - one-hot grant pulse: R205, R10, tick, A550, A200, A180, A10
module meter_scheduler #(
    parameter int MAX_TIME   = 9999,
    parameter int LOW_THRESH = 180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk1HZ,
    input  logic        clk20HZ,
    input  logic        Add10,
    input  logic        Add180,
    input  logic        Add200,
    input  logic        Add550,
    input  logic        Reset10,
    input  logic        Reset205,
    output logic [13:0] timeRemain,
    output logic        disp_on,
    output logic [1:0]  mstate,
    output logic [6:0]  served
);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_LOW     = 2'd1,
        ST_EXPIRED = 2'd2
    } mstate_t;

    localparam logic [14:0] MAX15 = 15'(MAX_TIME);
    localparam logic [13:0] LOW_T = 14'(LOW_THRESH);

    // Bits 6:0 line up with the served/pending bit order; bit 7 is the blink base.
    logic [7:0] async_in;
    assign async_in = {clk20HZ, Reset205, Reset10, clk1HZ, Add550, Add200, Add180, Add10};

    logic [7:0]  sync1_q, sync1_d;
    logic [7:0]  sync2_q, sync2_d;
    logic [7:0]  sync3_q, sync3_d;
    logic [1:0]  warm_q, warm_d;
    logic [7:0]  rise;

    logic [6:0]  pend_q, pend_d;
    logic [6:0]  grant;
    logic [6:0]  served_q, served_d;
    logic [13:0] time_remain_q, time_remain_d;
    logic [14:0] add_k;
    logic [14:0] sum15;

    mstate_t     mst;
    mstate_t     prev_q, prev_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  limit;
    logic        disp_q, disp_d;

    // Synchroniser plus edge flop. For the first two cycles after reset the
    // edge flop loads the same value as sync2, so levels already high when
    // reset releases never look like rising edges.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        sync3_d = (warm_q == 2'd2) ? sync2_q : sync1_q;
        warm_d  = (warm_q == 2'd2) ? 2'd2 : warm_q + 2'd1;
    end

    assign rise = sync2_q & ~sync3_q;

    // Fixed-priority grant: highest bit index wins.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (pend_q[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Clear the granted bit first, then OR in new edges: a press arriving in
    // its own grant cycle stays pending instead of being swallowed.
    always_comb begin
        pend_d   = (pend_q & ~grant) | rise[6:0];
        served_d = grant;
    end

    always_comb begin
        add_k = 15'd0;
        if (grant[3]) add_k = 15'd550;
        if (grant[2]) add_k = 15'd200;
        if (grant[1]) add_k = 15'd180;
        if (grant[0]) add_k = 15'd10;
        // One bit wider than the register so a near-ceiling add cannot wrap.
        sum15 = {1'b0, time_remain_q} + add_k;

        time_remain_d = time_remain_q;
        if (grant[6]) begin
            time_remain_d = 14'd205;
        end else if (grant[5]) begin
            time_remain_d = 14'd10;
        end else if (grant[4]) begin
            time_remain_d = (time_remain_q != 14'd0) ? time_remain_q - 14'd1 : 14'd0;
        end else if (|grant[3:0]) begin
            time_remain_d = (sum15 > MAX15) ? MAX15[13:0] : sum15[13:0];
        end
    end

    always_comb begin
        if (time_remain_q == 14'd0) begin
            mst = ST_EXPIRED;
        end else if (time_remain_q < LOW_T) begin
            mst = ST_LOW;
        end else begin
            mst = ST_NORMAL;
        end
    end

    // Blink: count 20 Hz edges, toggle and restart at 20 (LOW) or 10 (EXPIRED).
    // Any state change restarts the pattern with the display on.
    always_comb begin
        prev_d = mst;
        cnt_d  = cnt_q;
        disp_d = disp_q;
        limit  = (mst == ST_LOW) ? 5'd20 : 5'd10;
        if (mst != prev_q) begin
            disp_d = 1'b1;
            cnt_d  = 5'd0;
        end else if (mst == ST_NORMAL) begin
            disp_d = 1'b1;
            cnt_d  = 5'd0;
        end else if (rise[7]) begin
            if (cnt_q + 5'd1 == limit) begin
                disp_d = ~disp_q;
                cnt_d  = 5'd0;
            end else begin
                cnt_d  = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            sync3_q       <= '0;
            warm_q        <= 2'd0;
            pend_q        <= '0;
            served_q      <= '0;
            time_remain_q <= '0;
            cnt_q         <= '0;
            prev_q        <= ST_NORMAL;
            disp_q        <= 1'b1;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            warm_q        <= warm_d;
            pend_q        <= pend_d;
            served_q      <= served_d;
            time_remain_q <= time_remain_d;
            cnt_q         <= cnt_d;
            prev_q        <= prev_d;
            disp_q        <= disp_d;
        end
    end

    assign timeRemain = time_remain_q;
    assign disp_on    = disp_q;
    assign mstate     = mst;
    assign served     = served_q;

endmodule
